// File: rtl/sb_mission_sequencer.sv
// sb_mission_sequencer: table-driven mission sequencer.
// Walks up to MAX_TASKS (start, end, op) legs. For each leg it requests a path from
// the planner, follows the returned nodes on node_hit events, requests turns at
// intermediate nodes and runs the pick/place op at the leg end.
// Optional build macro SB_PLAN_TIMEOUT_EN adds a planner watchdog (TIMEOUT_CYC cycles).
module sb_mission_sequencer #(
    parameter int NODE_W      = 5,
    parameter int PATH_LEN    = 10,
    parameter int MAX_TASKS   = 4,
    parameter int PAD_NODE    = 27,
    parameter int TIMEOUT_CYC = 50_000_000,
    localparam int TW = (MAX_TASKS > 1) ? $clog2(MAX_TASKS) : 1
) (
    input  logic                       clk_50,
    input  logic                       rst_n,
    input  logic                       task_wr_en,
    input  logic [TW-1:0]              task_wr_addr,
    input  logic [NODE_W-1:0]          task_wr_s,
    input  logic [NODE_W-1:0]          task_wr_e,
    input  logic [1:0]                 task_wr_op,
    input  logic [TW:0]                task_count,
    input  logic                       go,
    output logic                       plan_start,
    output logic [NODE_W-1:0]          plan_s,
    output logic [NODE_W-1:0]          plan_e,
    input  logic                       plan_done,
    input  logic [PATH_LEN*NODE_W-1:0] plan_path,
    input  logic                       node_hit,
    output logic                       turn_start,
    output logic [NODE_W-1:0]          prev_node,
    output logic [NODE_W-1:0]          cur_node,
    output logic [NODE_W-1:0]          next_node,
    input  logic                       turn_done,
    output logic                       color_start,
    input  logic                       color_done,
    output logic                       arm_start,
    output logic                       arm_op,
    input  logic                       arm_done,
    output logic                       busy,
    output logic                       mission_done,
    output logic                       err,
    output logic [TW-1:0]              task_idx
);

    localparam int IW = (PATH_LEN > 1) ? $clog2(PATH_LEN) : 1;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_PLAN   = 4'd1;
    localparam logic [3:0] S_SCAN   = 4'd2;
    localparam logic [3:0] S_FOLLOW = 4'd3;
    localparam logic [3:0] S_TURN   = 4'd4;
    localparam logic [3:0] S_OP     = 4'd5;
    localparam logic [3:0] S_COLOR  = 4'd6;
    localparam logic [3:0] S_ARM    = 4'd7;
    localparam logic [3:0] S_NEXT   = 4'd8;
    localparam logic [3:0] S_DONE   = 4'd9;
    localparam logic [3:0] S_ERR    = 4'd10;

    logic [3:0]        state;
    logic [NODE_W-1:0] tbl_s  [MAX_TASKS];
    logic [NODE_W-1:0] tbl_e  [MAX_TASKS];
    logic [1:0]        tbl_op [MAX_TASKS];
    logic [NODE_W-1:0] leg_s, leg_e;
    logic [1:0]        leg_op;
    logic [TW:0]       cnt_r;
    logic [TW-1:0]     task_idx_r;
    logic [NODE_W-1:0] path [PATH_LEN];
    logic [IW-1:0]     idx;
    logic [NODE_W-1:0] prev_r, cur_r, next_r;
    logic              arm_op_r;
    logic              zero_pulse;

    logic              scan_found;
    logic [IW-1:0]     scan_idx;
    logic [IW-1:0]     idx_dec, idx_m2;
    logic [TW-1:0]     nxt_idx;
    logic [TW:0]       tc_clamp;

    // Requests and status decode straight from the registered state, so a reset
    // clears every one of them without waiting for a clock edge.
    assign plan_start   = (state == S_PLAN);
    assign turn_start   = (state == S_TURN);
    assign color_start  = (state == S_COLOR);
    assign arm_start    = (state == S_ARM);
    assign err          = (state == S_ERR);
    assign busy         = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);
    assign mission_done = (state == S_DONE) || zero_pulse;
    assign plan_s       = leg_s;
    assign plan_e       = leg_e;
    assign prev_node    = prev_r;
    assign cur_node     = cur_r;
    assign next_node    = next_r;
    assign arm_op       = arm_op_r;
    assign task_idx     = task_idx_r;

    assign idx_dec  = idx - 1'b1;
    assign idx_m2   = (idx >= IW'(2)) ? idx - IW'(2) : '0;
    assign nxt_idx  = task_idx_r + 1'b1;
    // A count larger than the table would index past it; run the whole table instead.
    assign tc_clamp = (task_count > (TW+1)'(MAX_TASKS)) ? (TW+1)'(MAX_TASKS) : task_count;

    // Find the highest non-pad slot of the latched path: that slot is the leg start.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int i = 0; i < PATH_LEN; i++) begin
            if (path[i] != NODE_W'(PAD_NODE)) begin
                scan_found = 1'b1;
                scan_idx   = IW'(i);
            end
        end
    end

    // Task table writes, accepted only while no mission is running.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_TASKS; i++) begin
                tbl_s[i]  <= '0;
                tbl_e[i]  <= '0;
                tbl_op[i] <= '0;
            end
        end else if (task_wr_en && !busy && (int'(task_wr_addr) < MAX_TASKS)) begin
            tbl_s[task_wr_addr]  <= task_wr_s;
            tbl_e[task_wr_addr]  <= task_wr_e;
            tbl_op[task_wr_addr] <= task_wr_op;
        end
    end

`ifdef SB_PLAN_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYC + 1);
    logic [TOW-1:0] to_cnt;

    // Planner watchdog: counts cycles spent in PLAN_REQ, zero everywhere else.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n)               to_cnt <= '0;
        else if (state == S_PLAN) to_cnt <= to_cnt + 1'b1;
        else                      to_cnt <= '0;
    end
`endif

    // Mission FSM. Leg 0 is copied out of the table on go, so a table write in the
    // same cycle as go only affects later runs.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            leg_s      <= '0;
            leg_e      <= '0;
            leg_op     <= '0;
            cnt_r      <= '0;
            task_idx_r <= '0;
            idx        <= '0;
            prev_r     <= '0;
            cur_r      <= '0;
            next_r     <= '0;
            arm_op_r   <= 1'b0;
            zero_pulse <= 1'b0;
            for (int i = 0; i < PATH_LEN; i++) path[i] <= '0;
        end else begin
            zero_pulse <= 1'b0;
            case (state)
                S_IDLE, S_ERR: begin
                    if (go) begin
                        if (task_count == '0) begin
                            zero_pulse <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            task_idx_r <= '0;
                            cnt_r      <= tc_clamp;
                            leg_s      <= tbl_s[0];
                            leg_e      <= tbl_e[0];
                            leg_op     <= tbl_op[0];
                            state      <= S_PLAN;
                        end
                    end
                end
                S_PLAN: begin
                    if (plan_done) begin
                        for (int i = 0; i < PATH_LEN; i++)
                            path[i] <= plan_path[i*NODE_W +: NODE_W];
                        state <= S_SCAN;
                    end
`ifdef SB_PLAN_TIMEOUT_EN
                    else if (to_cnt == TOW'(TIMEOUT_CYC - 1)) state <= S_ERR;
`endif
                end
                S_SCAN: begin
                    idx <= scan_idx;
                    if (!scan_found || path[0] != leg_e) state <= S_ERR;
                    else if (scan_idx == '0)             state <= S_OP;
                    else                                 state <= S_FOLLOW;
                end
                S_FOLLOW: begin
                    // idx >= 1 here; the node just reached is path[idx-1].
                    if (node_hit) begin
                        idx <= idx_dec;
                        if (idx_dec == '0) begin
                            state <= S_OP;
                        end else begin
                            prev_r <= path[idx];
                            cur_r  <= path[idx_dec];
                            next_r <= path[idx_m2];
                            state  <= S_TURN;
                        end
                    end
                end
                S_TURN: begin
                    if (turn_done) state <= S_FOLLOW;
                end
                S_OP: begin
                    case (leg_op)
                        2'd1: begin arm_op_r <= 1'b0; state <= S_COLOR; end
                        2'd2: begin arm_op_r <= 1'b1; state <= S_ARM;   end
                        default: state <= S_NEXT;
                    endcase
                end
                S_COLOR: begin
                    if (color_done) state <= S_ARM;
                end
                S_ARM: begin
                    if (arm_done) state <= S_NEXT;
                end
                S_NEXT: begin
                    if ((TW+1)'(task_idx_r) + (TW+1)'(1) == cnt_r) begin
                        state <= S_DONE;
                    end else begin
                        task_idx_r <= nxt_idx;
                        leg_s      <= tbl_s[nxt_idx];
                        leg_e      <= tbl_e[nxt_idx];
                        leg_op     <= tbl_op[nxt_idx];
                        state      <= S_PLAN;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
